// File: rtl/trig_sync_pkg.sv
// Shared definitions for the coax trigger-alignment protocol (transmit and receive sides).
package trig_sync_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StQuiet,
        StTrain,
        StFlush
    } sync_state_e;

    localparam int unsigned NPULSE_DEF = 54;
    localparam int unsigned PERIOD_DEF = 4;
    localparam int unsigned QUIET_DEF  = 200;
    localparam int unsigned DLYW_DEF   = 3;

    // Clocks from the start edge to the end-of-window edge.
    function automatic int unsigned window_len(input int unsigned quiet,
                                               input int unsigned npulse,
                                               input int unsigned period,
                                               input int unsigned dlyw);
        return quiet + 1 + npulse * period + (1 << dlyw);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Single-channel programmable delay for the sync pulse train: 2**DLYW taps, tap 0 is the input.
module sync_delay_line #(
    parameter int unsigned DLYW = 3
) (
    input  logic            clk_adc,
    input  logic            nrst,
    input  logic            clr,
    input  logic            din,
    input  logic [DLYW-1:0] dly,
    output logic            dout
);

    localparam int unsigned DEPTH = 2 ** DLYW;

    logic [DEPTH-2:0] sr_q, sr_d;
    logic [DEPTH-1:0] taps;

    // taps[i] is din delayed by i clocks.
    assign taps = {sr_q, din};
    assign dout = taps[dly];

    always_comb begin
        sr_d = taps[DEPTH-2:0];
        if (clr) begin
            sr_d = '0;
        end
    end

    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/sync_pulse_tx.sv
// Coax sync-pulse transmitter: blanks trigger forwarding, then sends a fixed-period pulse train
// with per-channel delays so all pulses land in one receiver phase bin.
module sync_pulse_tx
    import trig_sync_pkg::*;
#(
    parameter int unsigned NCH    = 16,
    parameter int unsigned NPULSE = NPULSE_DEF,
    parameter int unsigned PERIOD = PERIOD_DEF,
    parameter int unsigned QUIET  = QUIET_DEF,
    parameter int unsigned DLYW   = DLYW_DEF
) (
    input  logic              clk_adc,
    input  logic              nrst,
    input  logic              sync_start,
    input  logic [NCH-1:0]    trig_in,
    input  logic [NCH*DLYW-1:0] dly_flat,
    output logic [NCH-1:0]    coax_out,
    output logic              sync_active,
    output logic [7:0]        pulse_cnt,
    output logic              done
);

    localparam int unsigned TAIL = 2 ** DLYW;
    localparam int unsigned TW   = $clog2(QUIET + TAIL + 1);
    localparam int unsigned PW   = $clog2(PERIOD);

    sync_state_e         state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [NCH*DLYW-1:0] dly_q, dly_d;
    logic [NCH-1:0]      coax_q, coax_d;
    logic                active_q, active_d;
    logic                done_q, done_d;

    logic                start;
    logic                base;
    logic [NCH-1:0]      dl_tap;

    assign start = (state_q == StIdle) && sync_start;
    assign base  = (state_q == StTrain) && (phase_q == '0);

    for (genvar c = 0; c < NCH; c++) begin : g_dl
        sync_delay_line #(
            .DLYW(DLYW)
        ) u_dl (
            .clk_adc(clk_adc),
            .nrst   (nrst),
            .clr    (start),
            .din    (base),
            .dly    (dly_q[c*DLYW +: DLYW]),
            .dout   (dl_tap[c])
        );
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        dly_d    = dly_q;
        coax_d   = dl_tap;
        active_d = active_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                coax_d = trig_in;
                if (sync_start) begin
                    state_d  = StQuiet;
                    timer_d  = '0;
                    cnt_d    = '0;
                    dly_d    = dly_flat;
                    coax_d   = '0;
                    active_d = 1'b1;
                end
            end
            StQuiet: begin
                if (timer_q == TW'(QUIET - 1)) begin
                    state_d = StTrain;
                    phase_d = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StTrain: begin
                phase_d = (phase_q == PW'(PERIOD - 1)) ? '0 : phase_q + 1'b1;
                if (base && (cnt_q < 8'(NPULSE))) begin
                    cnt_d = cnt_q + 8'd1;
                end
                // PERIOD >= 2, so the count is already final on the last phase of the last pulse.
                if ((phase_q == PW'(PERIOD - 1)) && (cnt_q == 8'(NPULSE))) begin
                    state_d = StFlush;
                    timer_d = '0;
                end
            end
            StFlush: begin
                if (timer_q == TW'(TAIL)) begin
                    state_d  = StIdle;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d  = StIdle;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            phase_q  <= '0;
            cnt_q    <= '0;
            dly_q    <= '0;
            coax_q   <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            dly_q    <= dly_d;
            coax_q   <= coax_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign coax_out    = coax_q;
    assign sync_active = active_q;
    assign pulse_cnt   = cnt_q;
    assign done        = done_q;

endmodule
